// File: rtl/bipn_cal_if.sv
// Bus bundle for the BIP calculator: frame data in, BIP/error results out.
interface bipn_cal_if #(
    parameter int unsigned BIPW = 8,
    parameter int unsigned DW   = 1,
    parameter int unsigned CNTW = 16
);
    localparam int unsigned EBW = $clog2(BIPW) + 1;

    logic            sof;
    logic            din_vld;
    logic [DW-1:0]   din;
    logic            mode;
    logic [BIPW-1:0] rxbip;
    logic            rxbip_vld;
    logic            cnt_clr;
    logic [BIPW-1:0] bip_pdo;
    logic            bip_vld;
    logic [EBW-1:0]  err_bits;
    logic            err_vld;
    logic [CNTW-1:0] err_cnt;

    modport master (
        output sof, din_vld, din, mode, rxbip, rxbip_vld, cnt_clr,
        input  bip_pdo, bip_vld, err_bits, err_vld, err_cnt
    );

    modport slave (
        input  sof, din_vld, din, mode, rxbip, rxbip_vld, cnt_clr,
        output bip_pdo, bip_vld, err_bits, err_vld, err_cnt
    );
endinterface

// File: rtl/bipn_cal.sv
// Bit-interleaved parity generator/checker with saturating error counter.
module bipn_cal #(
    parameter int unsigned BIPW = 8,
    parameter int unsigned DW   = 1,
    parameter int unsigned CNTW = 16
) (
    input  logic         clk155,
    input  logic         rst_n,
    bipn_cal_if.slave    bus
);
    localparam int unsigned NB  = BIPW / DW;
    localparam int unsigned PW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned EBW = $clog2(BIPW) + 1;
    localparam int unsigned SW  = ((CNTW > EBW) ? CNTW : EBW) + 1;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [BIPW-1:0] acc, acc_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic            frm_seen;
    logic            pub_done;
    logic [BIPW-1:0] bip_pdo_q;
    logic            bip_vld_q;
    logic [EBW-1:0]  err_bits_q;
    logic            err_vld_q;
    logic [CNTW-1:0] err_cnt_q, cnt_nxt;

    logic            cmp_c;
    logic [BIPW-1:0] diff_c;
    logic [EBW-1:0]  pop_c;
    logic [CNTW-1:0] base_c;
    logic [SW-1:0]   sum_c;

    // Next accumulator/pointer: sof restarts the frame at slice 0, valid beats fold into the current slice
    always_comb begin
        acc_nxt = acc;
        ptr_nxt = ptr;
        if (bus.sof) begin
            acc_nxt = '0;
            if (bus.din_vld) begin
                acc_nxt[DW-1:0] = bus.din;
            end
            ptr_nxt = (bus.din_vld && (NB > 1)) ? PW'(1) : '0;
        end else if (bus.din_vld) begin
            for (int unsigned s = 0; s < NB; s++) begin
                if (ptr == PW'(s)) begin
                    acc_nxt[s*DW +: DW] = acc[s*DW +: DW] ^ bus.din;
                end
            end
            ptr_nxt = (ptr == PW'(NB - 1)) ? '0 : ptr + PW'(1);
        end
    end

    // Compare against the currently published BIP (pre-update when coincident with sof)
    always_comb begin
        cmp_c  = bus.mode & bus.rxbip_vld & pub_done;
        diff_c = bus.rxbip ^ bip_pdo_q;
        pop_c  = '0;
        for (int unsigned i = 0; i < BIPW; i++) begin
            pop_c = pop_c + EBW'(diff_c[i]);
        end
    end

    // Saturating error counter; clear wins over the old count but still takes a coincident compare
    always_comb begin
        base_c  = bus.cnt_clr ? '0 : err_cnt_q;
        sum_c   = SW'(base_c) + SW'(pop_c);
        cnt_nxt = err_cnt_q;
        if (cmp_c) begin
            cnt_nxt = (sum_c > SW'(CNT_MAX)) ? CNT_MAX : CNTW'(sum_c);
        end else if (bus.cnt_clr) begin
            cnt_nxt = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk155 or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            ptr        <= '0;
            frm_seen   <= 1'b0;
            pub_done   <= 1'b0;
            bip_pdo_q  <= '0;
            bip_vld_q  <= 1'b0;
            err_bits_q <= '0;
            err_vld_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            acc       <= acc_nxt;
            ptr       <= ptr_nxt;
            bip_vld_q <= 1'b0;
            err_vld_q <= cmp_c;
            err_cnt_q <= cnt_nxt;
            if (cmp_c) begin
                err_bits_q <= pop_c;
            end
            if (bus.sof) begin
                frm_seen <= 1'b1;
                if (frm_seen) begin
                    bip_pdo_q <= acc;
                    bip_vld_q <= 1'b1;
                    pub_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.bip_pdo  = bip_pdo_q;
    assign bus.bip_vld  = bip_vld_q;
    assign bus.err_bits = err_bits_q;
    assign bus.err_vld  = err_vld_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_bipn_cal.sv
// Directed and randomized checks of bipn_cal across several parameter sets.
module tb_bipn_cal;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bipn_cal_if #(.BIPW(8),  .DW(1), .CNTW(16)) i0 ();
    bipn_cal_if #(.BIPW(8),  .DW(8), .CNTW(16)) i1 ();
    bipn_cal_if #(.BIPW(8),  .DW(8), .CNTW(4))  i2 ();
    bipn_cal_if #(.BIPW(24), .DW(8), .CNTW(16)) i3 ();

    bipn_cal #(.BIPW(8),  .DW(1), .CNTW(16)) u0 (.clk155(clk), .rst_n(rst_n), .bus(i0.slave));
    bipn_cal #(.BIPW(8),  .DW(8), .CNTW(16)) u1 (.clk155(clk), .rst_n(rst_n), .bus(i1.slave));
    bipn_cal #(.BIPW(8),  .DW(8), .CNTW(4))  u2 (.clk155(clk), .rst_n(rst_n), .bus(i2.slave));
    bipn_cal #(.BIPW(24), .DW(8), .CNTW(16)) u3 (.clk155(clk), .rst_n(rst_n), .bus(i3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state for the randomized phase on u0
    bit          fb[$];
    bit   [7:0]  pdo_m;
    bit          seen_m, pub_m, bv_m, ev_m;
    bit   [3:0]  eb_m;
    int unsigned cnt_m, base_m;
    logic        r_s, r_v, r_d, r_m, r_rv, r_cl;
    logic [7:0]  r_rx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level BIP: bit n of the frame lands in parity position n mod 8
    function automatic logic [7:0] fold_frame();
        logic [7:0] r;
        r = '0;
        foreach (fb[i]) r[i % 8] = r[i % 8] ^ fb[i];
        return r;
    endfunction

    task automatic quiet_all();
        i0.sof = 0; i0.din_vld = 0; i0.din = '0; i0.mode = 0; i0.rxbip = '0; i0.rxbip_vld = 0; i0.cnt_clr = 0;
        i1.sof = 0; i1.din_vld = 0; i1.din = '0; i1.mode = 0; i1.rxbip = '0; i1.rxbip_vld = 0; i1.cnt_clr = 0;
        i2.sof = 0; i2.din_vld = 0; i2.din = '0; i2.mode = 0; i2.rxbip = '0; i2.rxbip_vld = 0; i2.cnt_clr = 0;
        i3.sof = 0; i3.din_vld = 0; i3.din = '0; i3.mode = 0; i3.rxbip = '0; i3.rxbip_vld = 0; i3.cnt_clr = 0;
    endtask

    initial begin
        logic [15:0] ser;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        quiet_all();
        tick();
        tick();
        chk("rst_pdo",  64'(i0.bip_pdo),  64'(0));
        chk("rst_bvld", 64'(i0.bip_vld),  64'(0));
        chk("rst_ebit", 64'(i0.err_bits), 64'(0));
        chk("rst_evld", 64'(i0.err_vld),  64'(0));
        chk("rst_cnt",  64'(i0.err_cnt),  64'(0));
        rst_n = 1'b1;
        tick();

        // Serial BIP-8: 0xA5 then 0x3C, LSB first
        i0.sof = 1;
        tick();
        i0.sof = 0;
        chk("first_sof_no_vld", 64'(i0.bip_vld), 64'(0));
        chk("first_sof_pdo", 64'(i0.bip_pdo), 64'(0));
        ser = 16'h3CA5;
        for (int k = 0; k < 16; k++) begin
            i0.din_vld = 1;
            i0.din     = ser[k];
            tick();
        end
        i0.din_vld = 0;
        i0.sof     = 1;
        tick();
        i0.sof = 0;
        chk("ser_bvld", 64'(i0.bip_vld), 64'(1));
        chk("ser_pdo",  64'(i0.bip_pdo), 64'(8'h99));

        // Randomized frames and compares on u0 against the frame-level model
        seen_m = 1; pub_m = 1; pdo_m = 8'h99; cnt_m = 0; eb_m = 0;
        fb.delete();
        for (int c = 0; c < 400; c++) begin
            r_s  = ($urandom_range(0, 19) == 0);
            r_v  = ($urandom_range(0, 3) != 0);
            r_d  = 1'($urandom_range(0, 1));
            r_m  = ($urandom_range(0, 3) != 0);
            r_rv = ($urandom_range(0, 4) == 0);
            r_cl = ($urandom_range(0, 15) == 0);
            r_rx = 8'($urandom);
            i0.sof = r_s; i0.din_vld = r_v; i0.din = r_d; i0.mode = r_m;
            i0.rxbip = r_rx; i0.rxbip_vld = r_rv; i0.cnt_clr = r_cl;
            ev_m = r_m && r_rv && pub_m;
            if (ev_m) begin
                eb_m   = 4'($countones(r_rx ^ pdo_m));
                base_m = r_cl ? 0 : cnt_m;
                cnt_m  = (base_m + eb_m > 65535) ? 65535 : base_m + eb_m;
            end else if (r_cl) begin
                cnt_m = 0;
            end
            bv_m = 0;
            if (r_s) begin
                if (seen_m) begin
                    pdo_m = fold_frame();
                    pub_m = 1;
                    bv_m  = 1;
                end
                seen_m = 1;
                fb.delete();
                if (r_v) fb.push_back(r_d);
            end else if (r_v) begin
                fb.push_back(r_d);
            end
            tick();
            chk("rnd_bvld", 64'(i0.bip_vld),  64'(bv_m));
            chk("rnd_pdo",  64'(i0.bip_pdo),  64'(pdo_m));
            chk("rnd_evld", 64'(i0.err_vld),  64'(ev_m));
            chk("rnd_ebit", 64'(i0.err_bits), 64'(eb_m));
            chk("rnd_cnt",  64'(i0.err_cnt),  64'(cnt_m));
        end
        i0.sof = 0; i0.din_vld = 0; i0.rxbip_vld = 0; i0.cnt_clr = 0; i0.mode = 0;
        tick();

        // Byte-wide BIP-8 with gaps; compare before any publish is ignored
        i1.mode = 1; i1.rxbip = 8'h55; i1.rxbip_vld = 1;
        i1.sof = 1; i1.din_vld = 1; i1.din = 8'h12;
        tick();
        i1.sof = 0; i1.rxbip_vld = 0;
        chk("pre_pub_evld", 64'(i1.err_vld), 64'(0));
        chk("b8_first_bvld", 64'(i1.bip_vld), 64'(0));
        i1.din = 8'h34;
        tick();
        i1.din_vld = 0;
        tick();
        tick();
        i1.din_vld = 1; i1.din = 8'h56;
        tick();
        i1.din_vld = 0; i1.sof = 1; i1.rxbip_vld = 1;
        tick();
        i1.sof = 0; i1.rxbip_vld = 0;
        chk("b8_bvld", 64'(i1.bip_vld), 64'(1));
        chk("b8_pdo",  64'(i1.bip_pdo), 64'(8'h70));
        chk("first_pub_cmp_ignored", 64'(i1.err_vld), 64'(0));

        // Check mode compares, mode=0 ignored, counter clear
        i1.mode = 0; i1.rxbip = 8'h71; i1.rxbip_vld = 1;
        tick();
        chk("mode0_evld", 64'(i1.err_vld),  64'(0));
        chk("mode0_ebit", 64'(i1.err_bits), 64'(0));
        i1.mode = 1;
        tick();
        i1.rxbip_vld = 0;
        chk("cmp1_ebit", 64'(i1.err_bits), 64'(1));
        chk("cmp1_evld", 64'(i1.err_vld),  64'(1));
        chk("cmp1_cnt",  64'(i1.err_cnt),  64'(1));
        i1.rxbip_vld = 1;
        tick();
        i1.rxbip_vld = 0;
        chk("cmp2_cnt", 64'(i1.err_cnt), 64'(2));
        tick();
        chk("evld_pulse", 64'(i1.err_vld), 64'(0));
        i1.cnt_clr = 1;
        tick();
        i1.cnt_clr = 0;
        chk("clr_cnt",  64'(i1.err_cnt), 64'(0));
        chk("clr_evld", 64'(i1.err_vld), 64'(0));

        // Compare coincident with a publishing sof uses the previous BIP
        i1.din_vld = 1; i1.din = 8'h0F;
        tick();
        i1.din_vld = 0; i1.sof = 1; i1.rxbip = 8'h70; i1.rxbip_vld = 1;
        tick();
        i1.sof = 0; i1.rxbip_vld = 0;
        chk("coinc_pdo",  64'(i1.bip_pdo),  64'(8'h0F));
        chk("coinc_bvld", 64'(i1.bip_vld),  64'(1));
        chk("coinc_evld", 64'(i1.err_vld),  64'(1));
        chk("coinc_ebit", 64'(i1.err_bits), 64'(0));

        // 4-bit counter saturation
        i2.sof = 1;
        tick();
        tick();
        i2.sof = 0;
        chk("sat_pub_bvld", 64'(i2.bip_vld), 64'(1));
        chk("sat_pub_pdo",  64'(i2.bip_pdo), 64'(0));
        i2.mode = 1; i2.rxbip = 8'hFF; i2.rxbip_vld = 1;
        tick();
        chk("sat_ebit", 64'(i2.err_bits), 64'(8));
        chk("sat_c8",   64'(i2.err_cnt),  64'(8));
        tick();
        chk("sat_c15",  64'(i2.err_cnt),  64'(15));
        tick();
        chk("sat_hold", 64'(i2.err_cnt),  64'(15));
        i2.cnt_clr = 1;
        tick();
        i2.cnt_clr = 0; i2.rxbip_vld = 0;
        chk("clr_with_cmp", 64'(i2.err_cnt), 64'(8));

        // BIP-24 byte-wide with slice wrap
        i3.sof = 1; i3.din_vld = 1; i3.din = 8'h01;
        tick();
        i3.sof = 0; i3.din = 8'h02;
        tick();
        i3.din = 8'h04;
        tick();
        i3.din = 8'h08;
        tick();
        i3.din_vld = 0; i3.sof = 1;
        tick();
        i3.sof = 0;
        chk("b24_bvld", 64'(i3.bip_vld), 64'(1));
        chk("b24_pdo",  64'(i3.bip_pdo), 64'(24'h040209));

        // Asynchronous reset mid-frame
        i0.din_vld = 1; i0.din = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_u0_pdo",  64'(i0.bip_pdo),  64'(0));
        chk("arst_u0_cnt",  64'(i0.err_cnt),  64'(0));
        chk("arst_u0_ebit", 64'(i0.err_bits), 64'(0));
        chk("arst_u1_pdo",  64'(i1.bip_pdo),  64'(0));
        chk("arst_u2_cnt",  64'(i2.err_cnt),  64'(0));
        chk("arst_u2_ebit", 64'(i2.err_bits), 64'(0));
        chk("arst_u3_pdo",  64'(i3.bip_pdo),  64'(0));
        #2;
        rst_n = 1'b1;
        i0.din_vld = 0; i0.sof = 1;
        tick();
        chk("post_rst_no_bvld", 64'(i0.bip_vld), 64'(0));
        tick();
        i0.sof = 0;
        chk("post_rst_second_bvld", 64'(i0.bip_vld), 64'(1));
        chk("post_rst_second_pdo",  64'(i0.bip_pdo), 64'(0));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bipn_cal.md
BIPN_CAL -- requirements
Module: bipn_cal

Interface
REQ-001 Parameter BIPW, default 8, BIP width in bits (8 for B1/B2, 24 for STM-1 B2 block).
REQ-002 Parameter DW, default 1, data bits per valid beat; BIPW % DW == 0 is required; other values are out of scope.
REQ-003 Parameter CNTW, default 16, error counter width.
REQ-004 clk155  input  1  single clock; all flops on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sof  input  1  first beat of a frame; qualified only by itself, not by din_vld.
REQ-007 din_vld  input  1  din carries valid data this cycle.
REQ-008 din  input  DW  frame data; din[0] is the earliest bit in transmission order.
REQ-009 mode  input  1  0 = generate, 1 = check; sampled every cycle.
REQ-010 rxbip  input  BIPW  received BIP value (check mode).
REQ-011 rxbip_vld  input  1  single-cycle strobe; rxbip is valid this cycle.
REQ-012 cnt_clr  input  1  synchronous clear of err_cnt.
REQ-013 bip_pdo  output  BIPW  BIP of the last completed frame.
REQ-014 bip_vld  output  1  one-cycle pulse; bip_pdo was updated this cycle.
REQ-015 err_bits  output  log2(BIPW)+1  number of mismatched bits in the last comparison.
REQ-016 err_vld  output  1  one-cycle pulse; err_bits was updated this cycle.
REQ-017 err_cnt  output  CNTW  saturating accumulated count of error bits.

Function
REQ-018 Accumulator acc[BIPW-1:0] and beat pointer ptr, range 0..BIPW/DW-1, wrap modulo BIPW/DW.
REQ-019 Valid beat without sof: acc[ptr*DW +: DW] ^= din; ptr increments with wrap.
REQ-020 Cycle without din_vld and without sof: acc and ptr hold.
REQ-021 sof cycle: bip_pdo <= acc (the completed frame); acc <= {0, din} at slice 0 if din_vld, else all zeros; ptr <= 1 if din_vld, else 0.
REQ-022 bip_vld pulses the cycle after sof (latency 1) only when a previous sof has been seen since reset (flag frm_seen); the first sof after reset publishes nothing and does not update bip_pdo.
REQ-023 Back-to-back sof cycles each publish; the second sof publishes the (possibly zero) acc from the first.
REQ-024 Check mode: on rxbip_vld with frm_seen and at least one publish done, err_bits <= popcount(rxbip ^ bip_pdo) and err_vld pulses the next cycle.
REQ-025 rxbip_vld in the same cycle as a publishing sof compares against the bip_pdo value before update, i.e. the previous frame's BIP.
REQ-026 rxbip_vld before the first publish, or while mode = 0, is ignored: no err_vld, err_bits holds.
REQ-027 err_cnt += err_bits on each err_vld-producing compare, saturating at 2^CNTW-1.
REQ-028 cnt_clr has priority: err_cnt <= 0, or <= err_bits_new if a compare completes in the same cycle.
REQ-029 A mode change takes effect on the next cycle; accumulation is unaffected by mode.

Reset
REQ-030 Asynchronous assertion of rst_n = 0 clears acc, ptr, frm_seen, bip_pdo, bip_vld, err_bits, err_vld and err_cnt to 0 immediately.
REQ-031 Reset mid-frame discards the partial frame; the first sof after deassertion is treated as the first sof after reset.
REQ-032 Deassertion is synchronised externally; the block adds no reset synchroniser.

Verification
REQ-033 BIPW=8, DW=1: sof, serial 0xA5 then 0x3C (LSB first, 16 valid beats), sof -> bip_pdo = 0x99 with bip_vld pulsed one cycle after the second sof.
REQ-034 BIPW=8, DW=8: sof with 0x12, then 0x34, 0x56, then sof -> bip_pdo = 0x70; din_vld gaps inserted mid-frame leave the result unchanged.
REQ-035 Check mode, published 0x70, rxbip = 0x71 with rxbip_vld -> err_bits = 1, err_vld pulses, err_cnt = 1; a repeat compare gives err_cnt = 2; cnt_clr alone gives err_cnt = 0.
REQ-036 CNTW=4, drive compares of 8 error bits each: counts 8, then 15, then 15 (saturated); cnt_clr coincident with a compare -> err_cnt = 8.
REQ-037 First sof after reset -> no bip_vld; rxbip_vld before any publish -> no err_vld; rst_n pulsed mid-frame -> all outputs 0 at once and the next sof produces no bip_vld.
REQ-038 BIPW=24, DW=8: sof with 0x01, 0x02, 0x04, 0x08 -> bip_pdo = 0x040209 (the fourth byte wraps to slice 0).
